// File: rtl/pool_mode_core.sv
`default_nettype none
// ============================================================================
// Module  : pool_mode_core
// Brief   : Per-window pooling engine. Reduces one WIN_SIZE x WIN_SIZE window
//           per channel per cycle to a single value using max, average or min,
//           selected per frame. Fully pipelined, fixed latency of
//           clog2(WIN_SIZE*WIN_SIZE)+1 cycles for every mode.
// Ports   : clk        - clock
//           reset_n    - asynchronous active-low reset
//           mode       - 00 max, 01 average, 10 min, 11 max; latched at frame start
//           fin_start  - first window of a frame (qualified by din_vld)
//           din_vld    - window valid
//           din        - packed [CH_NUM][WIN_SIZE][WIN_SIZE][DATA_WIDTH]
//           fout_start - first output of a frame
//           dout_vld   - pooled result valid
//           dout       - packed [CH_NUM][DATA_WIDTH]
// Options : POOL_RELU_EN - clamp negative results to zero (signed data only)
// Revision: 1.0 - initial release
// ============================================================================
module pool_mode_core #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN_SIZE   = 3,
    parameter int CH_NUM     = 128,
    parameter int SIGNED     = 0,
    parameter int FRAC       = 16
) (
    input  wire logic                                         clk,
    input  wire logic                                         reset_n,
    input  wire logic [1:0]                                   mode,
    input  wire logic                                         fin_start,
    input  wire logic                                         din_vld,
    input  wire logic [CH_NUM*WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0] din,
    output logic                                              fout_start,
    output logic                                              dout_vld,
    output logic [CH_NUM*DATA_WIDTH-1:0]                      dout
);

    localparam int c_n  = WIN_SIZE * WIN_SIZE;
    localparam int c_d  = $clog2(c_n);
    localparam int c_aw = DATA_WIDTH + c_d;
    // Product width: covers |sum| * RECIP plus rounding with headroom for sign.
    localparam int c_pw = c_aw + FRAC + 2;
    localparam logic [c_pw-1:0] c_recip = c_pw'(((1 << FRAC) + c_n / 2) / c_n);
    localparam logic [c_pw-1:0] c_half  = c_pw'(1) << (FRAC - 1);
    localparam logic [1:0] c_mode_avg = 2'b01;
    localparam logic [1:0] c_mode_min = 2'b10;

    // Number of live operands entering reduction stage s.
    function automatic int stage_cnt(input int s);
        int c;
        c = c_n;
        for (int i = 0; i < s; i++) c = (c + 1) / 2;
        return c;
    endfunction

    // One reduction node; the comparison follows the data signedness, the
    // sum is exact because operands are already extended to c_aw bits.
    function automatic logic [c_aw-1:0] reduce2(input logic [c_aw-1:0] a,
                                                input logic [c_aw-1:0] b,
                                                input logic [1:0]      m);
        logic a_gt;
        a_gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
        case (m)
            c_mode_avg: return a + b;
            c_mode_min: return a_gt ? b : a;
            default:    return a_gt ? a : b;
        endcase
    endfunction

    logic             r_mode_q;
    logic [1:0]       r_mode_frame;
    logic             w_first;
    logic [1:0]       w_mode_in;
    logic [c_aw-1:0]  w_in [CH_NUM][c_n];

    assign w_first = fin_start & din_vld;
    // The first window of a frame uses the incoming mode directly so it needs
    // no extra cycle; later windows use the latched copy.
    assign w_mode_in = w_first ? mode : r_mode_frame;
    assign r_mode_q  = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_frame <= 2'b00;
        end else if (w_first) begin
            r_mode_frame <= mode;
        end
    end

    always_comb begin
        for (int ch = 0; ch < CH_NUM; ch++) begin
            for (int k = 0; k < c_n; k++) begin
                w_in[ch][k] = {{c_d{(SIGNED != 0) & din[(ch*c_n + k)*DATA_WIDTH + DATA_WIDTH - 1]}},
                               din[(ch*c_n + k)*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // Binary reduction tree; valid, start and mode travel with each window.
    for (genvar s = 0; s < c_d; s++) begin : g_stage
        localparam int c_in  = stage_cnt(s);
        localparam int c_out = stage_cnt(s + 1);

        logic [c_aw-1:0] w_src [CH_NUM][c_in];
        logic            w_src_vld;
        logic            w_src_start;
        logic [1:0]      w_src_mode;
        logic [c_aw-1:0] r_data [CH_NUM][c_out];
        logic            r_vld;
        logic            r_start;
        logic [1:0]      r_mode;

        if (s == 0) begin : g_src_in
            assign w_src       = w_in;
            assign w_src_vld   = din_vld;
            assign w_src_start = w_first;
            assign w_src_mode  = w_mode_in;
        end else begin : g_src_prev
            assign w_src       = g_stage[s-1].r_data;
            assign w_src_vld   = g_stage[s-1].r_vld;
            assign w_src_start = g_stage[s-1].r_start;
            assign w_src_mode  = g_stage[s-1].r_mode;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_vld   <= 1'b0;
                r_start <= 1'b0;
                r_mode  <= 2'b00;
            end else begin
                r_vld   <= w_src_vld;
                r_start <= w_src_start;
                r_mode  <= w_src_mode;
            end
        end

        for (genvar j = 0; j < c_out; j++) begin : g_elem
            if (2*j + 1 < c_in) begin : g_pair
                always_ff @(posedge clk) begin
                    for (int ch = 0; ch < CH_NUM; ch++) begin
                        r_data[ch][j] <= reduce2(w_src[ch][2*j], w_src[ch][2*j+1], w_src_mode);
                    end
                end
            end else begin : g_pass
                // Unpaired operand is simply delayed to keep stages aligned.
                always_ff @(posedge clk) begin
                    for (int ch = 0; ch < CH_NUM; ch++) begin
                        r_data[ch][j] <= w_src[ch][2*j];
                    end
                end
            end
        end
    end

    logic [c_pw-1:0]       w_ext [CH_NUM];
    logic [c_pw-1:0]       w_rnd [CH_NUM];
    logic [DATA_WIDTH-1:0] w_pre [CH_NUM];
    logic [DATA_WIDTH-1:0] w_res [CH_NUM];

    // Average divides by N through a fixed-point reciprocal with rounding;
    // taking bits [FRAC +: DATA_WIDTH] of the two's-complement product is the
    // truncated arithmetic (or logical) shift.
    always_comb begin
        for (int ch = 0; ch < CH_NUM; ch++) begin
            w_ext[ch] = {{(c_pw - c_aw){(SIGNED != 0) & g_stage[c_d-1].r_data[ch][0][c_aw-1]}},
                         g_stage[c_d-1].r_data[ch][0]};
            w_rnd[ch] = w_ext[ch] * c_recip + c_half;
            if (g_stage[c_d-1].r_mode == c_mode_avg) begin
                w_pre[ch] = w_rnd[ch][FRAC +: DATA_WIDTH];
            end else begin
                w_pre[ch] = g_stage[c_d-1].r_data[ch][0][DATA_WIDTH-1:0];
            end
`ifdef POOL_RELU_EN
            if ((SIGNED != 0) && w_pre[ch][DATA_WIDTH-1]) begin
                w_res[ch] = '0;
            end else begin
                w_res[ch] = w_pre[ch];
            end
`else
            w_res[ch] = w_pre[ch];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_vld   <= 1'b0;
            fout_start <= 1'b0;
            dout       <= '0;
        end else begin
            dout_vld   <= g_stage[c_d-1].r_vld;
            fout_start <= g_stage[c_d-1].r_start & g_stage[c_d-1].r_vld;
            for (int ch = 0; ch < CH_NUM; ch++) begin
                dout[ch*DATA_WIDTH +: DATA_WIDTH] <= w_res[ch];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_mode_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_pool_mode_core
// Brief   : Directed self-checking bench for pool_mode_core. Two instances
//           (unsigned and signed data) share clock, reset and stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pool_mode_core;

    localparam int DW = 8;
    localparam int WS = 3;
    localparam int CH = 4;
    localparam int NE = WS * WS;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [1:0]         mode;
    logic               fin_start;
    logic               din_vld;
    logic [CH*NE*DW-1:0] din;
    logic               fs_u, vld_u, fs_s, vld_s;
    logic [CH*DW-1:0]   dout_u, dout_s;

    int n_tests = 0;
    int n_fail  = 0;
    bit relu;

    int s_vld [8];
    int s_fs  [8];
    int s_mode[8];
    int s_base[8];
    int s_emode[8];

    always #5 clk = ~clk;

    pool_mode_core #(.DATA_WIDTH(DW), .WIN_SIZE(WS), .CH_NUM(CH), .SIGNED(0), .FRAC(16)) u_dut_u (
        .clk(clk), .reset_n(reset_n), .mode(mode), .fin_start(fin_start), .din_vld(din_vld),
        .din(din), .fout_start(fs_u), .dout_vld(vld_u), .dout(dout_u));

    pool_mode_core #(.DATA_WIDTH(DW), .WIN_SIZE(WS), .CH_NUM(CH), .SIGNED(1), .FRAC(16)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .mode(mode), .fin_start(fin_start), .din_vld(din_vld),
        .din(din), .fout_start(fs_s), .dout_vld(vld_s), .dout(dout_s));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Element k of channel ch = base + k*stride + ch*choff (mod 256).
    task automatic set_din(input int base, input int stride, input int choff);
        for (int ch = 0; ch < CH; ch++)
            for (int k = 0; k < NE; k++)
                din[(ch*NE + k)*DW +: DW] = 8'(base + k*stride + ch*choff);
    endtask

    function automatic logic [31:0] rep(input int v0, input int choff);
        logic [31:0] r;
        for (int ch = 0; ch < CH; ch++) r[ch*DW +: DW] = 8'(v0 + ch*choff);
        return r;
    endfunction

    // Single-window frame; returns with the result visible (5 cycles later).
    task automatic one_win(input logic [1:0] m, input int base, input int stride, input int choff);
        mode = m; fin_start = 1'b1; din_vld = 1'b1;
        set_din(base, stride, choff);
        step();
        fin_start = 1'b0; din_vld = 1'b0; mode = 2'b11;
        set_din(0, 0, 0);
        repeat (3) step();
        chk("vld_before_latency", {30'b0, vld_u, vld_s}, 32'h0);
        step();
    endtask

    // Streams n windows from the s_* tables, checking each output 5 cycles on.
    task automatic run_stream(input int n, input string tag);
        for (int c = 0; c < n + 5; c++) begin
            if (c < n) begin
                din_vld = 1'(s_vld[c]); fin_start = 1'(s_fs[c]); mode = 2'(s_mode[c]);
                set_din(s_base[c], 1, 10);
            end else begin
                din_vld = 1'b0; fin_start = 1'b0; mode = 2'b00;
            end
            step();
            if (c >= 4 && c - 4 < n) begin
                int w;
                int e;
                w = c - 4;
                chk($sformatf("%s_vld_w%0d", tag, w), {31'b0, vld_u}, 32'(s_vld[w]));
                chk($sformatf("%s_fs_w%0d", tag, w), {31'b0, fs_u}, 32'(s_vld[w] & s_fs[w]));
                if (s_vld[w] != 0) begin
                    e = (s_emode[w] == 0) ? s_base[w] + 8 :
                        (s_emode[w] == 1) ? s_base[w] + 4 : s_base[w];
                    chk($sformatf("%s_dout_w%0d", tag, w), dout_u, rep(e, 10));
                end
            end
        end
    endtask

    initial begin
`ifdef POOL_RELU_EN
        relu = 1'b1;
`else
        relu = 1'b0;
`endif
        reset_n = 1'b0; mode = 2'b00; fin_start = 1'b0; din_vld = 1'b0; din = '0;
        repeat (2) step();
        chk("reset_vld", {30'b0, vld_u, vld_s}, 32'h0);
        chk("reset_fs", {30'b0, fs_u, fs_s}, 32'h0);
        chk("reset_dout_u", dout_u, 32'h0);
        chk("reset_dout_s", dout_s, 32'h0);
        reset_n = 1'b1;
        step();

        // Unsigned: 1..9 (+10 per channel); max sits on the unpaired element.
        one_win(2'b00, 1, 1, 10);
        chk("max_vld", {31'b0, vld_u}, 32'h1);
        chk("max_fs", {31'b0, fs_u}, 32'h1);
        chk("max_dout", dout_u, rep(9, 10));
        step();
        chk("max_vld_drop", {30'b0, vld_u, fs_u}, 32'h0);

        one_win(2'b01, 1, 1, 10);
        chk("avg_vld", {31'b0, vld_u}, 32'h1);
        chk("avg_dout", dout_u, rep(5, 10));

        one_win(2'b10, 1, 1, 10);
        chk("min_vld", {31'b0, vld_u}, 32'h1);
        chk("min_dout", dout_u, rep(1, 10));

        one_win(2'b10, 20, -1, 10);
        chk("min_desc_dout", dout_u, rep(12, 10));

        one_win(2'b11, 20, -1, 10);
        chk("rsvd_as_max_dout", dout_u, rep(20, 10));

        // Signed data.
        one_win(2'b01, -3, 0, 0);
        chk("s_avg_vld", {31'b0, vld_s}, 32'h1);
        chk("s_avg_neg3", dout_s, relu ? 32'h0 : rep(-3, 0));

        one_win(2'b00, -128, 1, 0);
        chk("s_max_neg", dout_s, relu ? 32'h0 : rep(-120, 0));

        one_win(2'b10, -128, 1, 0);
        chk("s_min_neg", dout_s, relu ? 32'h0 : rep(-128, 0));

        // Frame A (max, mode pin changes mid-frame) then frame B back-to-back (avg).
        s_vld   = '{1, 1, 1, 1, 1, 1, 1, 1};
        s_fs    = '{1, 0, 0, 0, 0, 0, 1, 0};
        s_mode  = '{0, 0, 0, 1, 1, 1, 1, 3};
        s_base  = '{1, 4, 7, 10, 13, 16, 19, 22};
        s_emode = '{0, 0, 0, 0, 0, 0, 1, 1};
        run_stream(8, "frames");

        // Valid pattern with bubbles, min mode.
        s_vld   = '{1, 0, 1, 1, 0, 0, 0, 0};
        s_fs    = '{1, 0, 0, 0, 0, 0, 0, 0};
        s_mode  = '{2, 0, 0, 0, 0, 0, 0, 0};
        s_base  = '{30, 33, 36, 39, 42, 0, 0, 0};
        s_emode = '{2, 2, 2, 2, 2, 2, 2, 2};
        run_stream(5, "bubbles");

        // Reset with three windows in flight.
        mode = 2'b01; fin_start = 1'b1; din_vld = 1'b1; set_din(50, 1, 0);
        step();
        fin_start = 1'b0; set_din(60, 1, 0);
        step();
        set_din(70, 1, 0);
        step();
        din_vld = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_vld", {30'b0, vld_u, fs_u}, 32'h0);
        chk("midrst_dout", dout_u, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        // fin_start without din_vld must not load the mode.
        fin_start = 1'b1; mode = 2'b01;
        step();
        fin_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("postrst_idle_%0d", i), {30'b0, vld_u, vld_s}, 32'h0);
            step();
        end
        // No fin_start: latched mode is back to max, mode pin ignored.
        mode = 2'b10; din_vld = 1'b1; set_din(5, 2, 1);
        step();
        din_vld = 1'b0;
        repeat (4) step();
        chk("postrst_vld", {31'b0, vld_u}, 32'h1);
        chk("postrst_fs", {31'b0, fs_u}, 32'h0);
        chk("postrst_dout", dout_u, rep(21, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
